// File: rtl/multi_edge_detector.sv
// Multi-channel synchronizer, debouncer and edge detector.
// Define EDGE_AUTOREPEAT_EN to add per-channel auto-repeat pulses.
module multi_edge_detector #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MODE            = 0,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] signal,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] was_edge,
    output logic                any_edge
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EM = (MODE >= 0 && MODE <= 2) ? MODE : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_a;
    logic [CHANNELS-1:0] sync_b;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] toggle;
    logic [CHANNELS-1:0] qualify;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] edge_d;

    // Counter runs only while the synchronized input disagrees with level
    always_comb begin
        toggle = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (sync_b[i] != level[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        level_d = level ^ toggle;
    end

    always_comb begin
        qualify = '0;
        if (EM == 1) begin
            qualify = toggle & level;
        end else if (EM == 2) begin
            qualify = toggle;
        end else begin
            qualify = toggle & ~level;
        end
    end

`ifdef EDGE_AUTOREPEAT_EN
    localparam logic ACTIVE = (EM == 1) ? 1'b0 : 1'b1;
    localparam logic [15:0] DLY_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] PER_LAST = 16'(REPEAT_PERIOD - 1);

    logic [15:0]         rcnt_q [CHANNELS];
    logic [15:0]         rcnt_d [CHANNELS];
    logic [CHANNELS-1:0] armed_q;
    logic [CHANNELS-1:0] armed_d;
    logic [CHANNELS-1:0] phase_q;
    logic [CHANNELS-1:0] phase_d;
    logic [CHANNELS-1:0] repeat_hit;

    // Armed by a qualifying edge into the active level; phase selects delay vs period
    always_comb begin
        armed_d    = '0;
        phase_d    = '0;
        repeat_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rcnt_d[i] = '0;
            if (qualify[i] && level_d[i] == ACTIVE) begin
                armed_d[i] = 1'b1;
            end else if (armed_q[i] && level[i] == ACTIVE && !toggle[i]) begin
                armed_d[i] = 1'b1;
                phase_d[i] = phase_q[i];
                if (rcnt_q[i] == (phase_q[i] ? PER_LAST : DLY_LAST)) begin
                    repeat_hit[i] = 1'b1;
                    phase_d[i]    = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + 16'd1;
                end
            end
        end
        edge_d = qualify | repeat_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= '0;
            phase_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            armed_q <= armed_d;
            phase_q <= phase_d;
            for (int i = 0; i < CHANNELS; i++) begin
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end
`else
    always_comb begin
        edge_d = qualify;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a   <= '0;
            sync_b   <= '0;
            level    <= '0;
            was_edge <= '0;
            any_edge <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_a   <= signal;
            sync_b   <= sync_a;
            level    <= level_d;
            was_edge <= edge_d;
            any_edge <= |edge_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a new level must hold before acceptance, range 1..65535.
REQ-003 Parameter MODE, default 0: 0 = rising edges, 1 = falling edges, 2 = both edges.
REQ-004 Parameters REPEAT_DELAY, default 1000, and REPEAT_PERIOD, default 250: auto-repeat timing in cycles, range 1..65535; used only per REQ-020.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 signal  input  CHANNELS  raw asynchronous inputs (buttons/switches), bit i = channel i.
REQ-008 level  output  CHANNELS  registered debounced level per channel.
REQ-009 was_edge  output  CHANNELS  registered one-cycle pulse per channel on a qualifying edge.
REQ-010 any_edge  output  1  registered OR of all was_edge bits, same cycle as was_edge.

Function
REQ-011 Each channel SHALL pass signal through a 2-flop synchronizer before any other logic.
REQ-012 Per channel, a counter of width clog2(DEBOUNCE_CYCLES+1) SHALL increment each cycle the synchronized value differs from level and clear to 0 in any cycle it equals level.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and the synchronized value still differs, level SHALL toggle at that edge and the counter SHALL clear; the counter never exceeds DEBOUNCE_CYCLES-1.
REQ-014 A new input level held steady SHALL appear on level exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave level and was_edge unchanged.
REQ-015 was_edge[i] SHALL be 1 for exactly one cycle, registered at the same edge level[i] toggles, if and only if the toggle qualifies under MODE (0: 0->1, 1: 1->0, 2: either).
REQ-016 Channels SHALL be fully independent; simultaneous qualifying edges on several channels SHALL assert all corresponding was_edge bits in the same cycle.
REQ-017 MODE values other than 0..2 SHALL behave as MODE 0.

Reset
REQ-018 While rst_n is 0, synchronizers, counters, level, was_edge, any_edge, and repeat state SHALL all be 0 immediately, without waiting for a clock edge.
REQ-019 After rst_n deasserts, an input already held at 1 SHALL be treated as a fresh 0->1 transition and SHALL follow REQ-014/REQ-015. Reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-020 With EDGE_AUTOREPEAT_EN defined:
  - Active level = 1 for MODE 0/2, 0 for MODE 1.
  - While level[i] holds its active value, was_edge[i] SHALL pulse again REPEAT_DELAY cycles after the qualifying edge pulse, then every REPEAT_PERIOD cycles.
  - Leaving the active value or reset SHALL stop repeats and clear the per-channel repeat counter (width 16).
  - MODE 2 repeats only while level is 1.
REQ-021 Without EDGE_AUTOREPEAT_EN, no repeat logic SHALL be synthesized and was_edge SHALL pulse only on debounced transitions.

Verification
REQ-022 CHANNELS=4, DEBOUNCE_CYCLES=4, MODE=0; signal[0] 0->1 held -> level[0]=1 and was_edge[0]=any_edge=1 for one cycle, 6 edges after the first sampling edge.
REQ-023 Same config; signal[1] high for 3 cycles then low -> level[1] and was_edge[1] stay 0 throughout.
REQ-024 MODE=2, DEBOUNCE_CYCLES=4; signal[2] 0->1 held 20 cycles then 1->0 -> two single-cycle was_edge[2] pulses; MODE=1 with the same stimulus -> only the falling pulse.
REQ-025 signal=4'b1011 applied in one cycle, MODE=0 -> was_edge=4'b1011 in a single cycle with any_edge=1.
REQ-026 rst_n pulsed low at debounce count 2 while signal[0]=1 -> outputs 0 immediately; after release, pulse arrives a full 6 edges later (count restarted).
REQ-027 EDGE_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5; signal[3] held high 40 cycles -> was_edge[3] pulses at debounce acceptance (t0), t0+10, t0+15, t0+20, ..., ceasing when level[3] returns to 0.
